// File: rtl/ifu_fetch.sv
// Instruction fetch stage feeding decode from the instruction cache.
//
// Generates sequential word-aligned PCs, runs a single-outstanding registered request/address
// handshake toward the icache, absorbs redirects from execute and buffers returned instructions
// in a small FIFO that decode drains under id_ready_i backpressure.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cache_req_o         fetch request (registered)
//   cache_addr_o        fetch address (registered, stable while a request is outstanding)
//   cache_ready_i       one-cycle pulse: cache_rdata_i is valid for cache_addr_o
//   cache_rdata_i       instruction word
//   redirect_valid_i    one-cycle pulse: restart fetch at redirect_pc_i (bits [1:0] dropped)
//   redirect_pc_i       redirect target
//   if_valid_o          head instruction available to decode
//   if_pc_o, if_instr_o head entry of the instruction buffer
//   id_ready_i          decode consumes the head when if_valid_o && id_ready_i
module ifu_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  cache_req_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  input  logic                  cache_ready_i,
  input  logic [31:0]           cache_rdata_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  if_valid_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [31:0]           if_instr_o,
  input  logic                  id_ready_i
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StKill} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  req_q, req_d;

  logic [ADDR_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [31:0]           instr_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [CntW-1:0]       count_q;

  logic                  empty, full, push, pop, flush;
  logic [CntW-1:0]       count_pop;
  logic                  credit_idle, credit_wait;
  logic [ADDR_WIDTH-1:0] redir_pc, pc_plus4;
  logic                  unused_redir_lsb;

  assign redir_pc         = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc_i[1:0];
  assign pc_plus4         = fetch_pc_q + ADDR_WIDTH'(4);

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign pop   = !empty && id_ready_i;
  assign flush = redirect_valid_i;
  // A redirect on the response cycle drops the response.
  assign push  = (state_q == StWait) && cache_ready_i && !redirect_valid_i;

  // Credit: fifo_count + outstanding < depth, with a same-cycle pop already freeing its slot.
  // From WAIT the completing response occupies one slot and the new request reserves another.
  assign count_pop   = count_q - CntW'(pop);
  assign credit_idle = (count_pop < CntW'(FIFO_DEPTH));
  assign credit_wait = (count_pop < CntW'(FIFO_DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    unique case (state_q)
      StIdle: begin
        if (redirect_valid_i) begin
          fetch_pc_d = redir_pc;
        end else if (credit_idle) begin
          state_d = StWait;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      StWait: begin
        if (cache_ready_i) begin
          if (redirect_valid_i) begin
            fetch_pc_d = redir_pc;
            addr_d     = redir_pc;
          end else begin
            fetch_pc_d = pc_plus4;
            if (credit_wait) begin
              addr_d = pc_plus4;
            end else begin
              state_d = StIdle;
              req_d   = 1'b0;
            end
          end
        end else if (redirect_valid_i) begin
          // The cache is mid-access on addr_q; let it finish and throw the data away.
          fetch_pc_d = redir_pc;
          state_d    = StKill;
        end
      end
      StKill: begin
        if (redirect_valid_i) begin
          fetch_pc_d = redir_pc;
        end
        if (cache_ready_i) begin
          state_d = StWait;
          addr_d  = redirect_valid_i ? redir_pc : fetch_pc_q;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem_q[wptr_q]    <= addr_q;
      instr_mem_q[wptr_q] <= cache_rdata_i;
    end
  end

  assign cache_req_o  = req_q;
  assign cache_addr_o = addr_q;
  assign if_valid_o   = !empty;
  assign if_pc_o      = empty ? '0 : pc_mem_q[rptr_q];
  assign if_instr_o   = empty ? '0 : instr_mem_q[rptr_q];

  // The credit rule must make an overflowing push impossible.
  push_when_full_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
    else $error("ifu_fetch: push into full instruction buffer");

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: icache model with per-address latency, decode sink, redirects.
module tb_ifu_fetch;

  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cache_req;
  logic [31:0] cache_addr;
  logic        cache_ready = 1'b0;
  logic [31:0] cache_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready = 1'b0;

  // Owned by the cache/decode model process.
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [31:0] cur_addr = '0;
  word_q_t     issued;
  word_q_t     cons_pc;
  word_q_t     cons_instr;
  int          stab_err = 0;
  int          seen_seq = 0;
  int          post_pend = 0;
  logic        post_valid = 1'b1;
  logic [31:0] post_addr = '0;

  // Owned by the main stimulus process.
  logic [31:0] miss_addr = 32'h1;
  int          miss_lat = 2;
  int          arm_seq = 0;
  int          arm_mode = 0;
  logic [31:0] arm_addr = '0;
  logic [31:0] arm_pc = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          ib, cb;

  ifu_fetch #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0000_0100),
    .FIFO_DEPTH(2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cache_req_o     (cache_req),
    .cache_addr_o    (cache_addr),
    .cache_ready_i   (cache_ready),
    .cache_rdata_i   (cache_rdata),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .if_valid_o      (if_valid),
    .if_pc_o         (if_pc),
    .if_instr_o      (if_instr),
    .id_ready_i      (id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC3C3_3C3C;
  endfunction

  function automatic logic [31:0] at_q(input word_q_t q, input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int count_of(input word_q_t q, input int from, input logic [31:0] v);
    int n = 0;
    for (int i = from; i < q.size(); i++) if (q[i] == v) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cache and decode model: everything is driven and sampled on the falling edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy           = 1'b0;
      cache_ready    = 1'b0;
      redirect_valid = 1'b0;
      post_pend      = 0;
    end else begin
      if (post_pend != 0) begin
        post_valid = if_valid;
        post_addr  = cache_addr;
        post_pend  = 0;
      end
      if (if_valid && id_ready) begin
        cons_pc.push_back(if_pc);
        cons_instr.push_back(if_instr);
      end
      cache_ready    = 1'b0;
      redirect_valid = 1'b0;
      if (busy) begin
        if (cache_addr != cur_addr || !cache_req) stab_err++;
        if (cnt == 0) begin
          cache_ready = 1'b1;
          cache_rdata = dat(cur_addr);
          busy        = 1'b0;
        end else begin
          cnt--;
        end
      end else if (cache_req) begin
        busy     = 1'b1;
        cur_addr = cache_addr;
        issued.push_back(cache_addr);
        cnt = ((cache_addr == miss_addr) ? miss_lat : 2) - 2;
      end
      if (arm_seq != seen_seq && (arm_mode == 0 || (cache_ready && cur_addr == arm_addr))) begin
        redirect_valid = 1'b1;
        redirect_pc    = arm_pc;
        seen_seq       = arm_seq;
        post_pend      = 1;
      end
    end
  end

  // mode 0: pulse on the next cycle; mode 1: pulse together with cache_ready for on_addr.
  task automatic do_redirect(input int mode, input logic [31:0] on_addr, input logic [31:0] pc,
                             input string tag);
    arm_mode = mode;
    arm_addr = on_addr;
    arm_pc   = pc;
    arm_seq++;
    for (int i = 0; i < 40 && seen_seq != arm_seq; i++) tick(1);
    check({tag, "_fired"}, 32'(seen_seq), 32'(arm_seq));
    tick(1);
    check({tag, "_flushed"}, 32'(post_valid), 32'h0);
    if (mode == 1) check({tag, "_reissue"}, post_addr, {pc[31:2], 2'b00});
  endtask

  task automatic wait_issued(input int n, input string tag);
    for (int i = 0; i < 60 && issued.size() < n; i++) tick(1);
    check(tag, 32'(issued.size() >= n), 32'h1);
  endtask

  task automatic do_reset(input logic rdy);
    rst_n    = 1'b0;
    id_ready = rdy;
    tick(2);
    rst_n = 1'b1;
    ib    = issued.size();
    cb    = cons_pc.size();
  endtask

  initial begin
    // Reset state, then straight-line fetch with a 2-cycle hit.
    id_ready = 1'b1;
    tick(1);
    check("rst_req", 32'(cache_req), 32'h0);
    check("rst_addr", cache_addr, 32'h100);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    do_reset(1'b1);
    tick(12);
    check("seq_a0", at_q(issued, ib), 32'h100);
    check("seq_a1", at_q(issued, ib + 1), 32'h104);
    check("seq_a2", at_q(issued, ib + 2), 32'h108);
    check("seq_pc0", at_q(cons_pc, cb), 32'h100);
    check("seq_pc1", at_q(cons_pc, cb + 1), 32'h104);
    check("seq_in0", at_q(cons_instr, cb), dat(32'h100));
    check("seq_in1", at_q(cons_instr, cb + 1), dat(32'h104));

    // Backpressure: two entries buffered, request drops, then resume in order.
    do_reset(1'b0);
    tick(10);
    check("bp_issued", 32'(issued.size() - ib), 32'h2);
    check("bp_req", 32'(cache_req), 32'h0);
    check("bp_valid", 32'(if_valid), 32'h1);
    check("bp_pc", if_pc, 32'h100);
    check("bp_instr", if_instr, dat(32'h100));
    id_ready = 1'b1;
    tick(10);
    check("bp_c0", at_q(cons_pc, cb), 32'h100);
    check("bp_c1", at_q(cons_pc, cb + 1), 32'h104);
    check("bp_c2", at_q(cons_pc, cb + 2), 32'h108);
    check("bp_a2", at_q(issued, ib + 2), 32'h108);

    // Long miss at 0x200 with a redirect to 0x403 mid-access.
    miss_addr = 32'h200;
    miss_lat  = 12;
    do_reset(1'b0);
    tick(10);
    ib = issued.size();
    cb = cons_pc.size();
    do_redirect(0, 32'h0, 32'h200, "idle_redir");
    id_ready = 1'b1;
    wait_issued(ib + 1, "miss_issue");
    tick(3);
    do_redirect(0, 32'h0, 32'h403, "miss_redir");
    tick(25);
    check("miss_a0", at_q(issued, ib), 32'h200);
    check("miss_a1", at_q(issued, ib + 1), 32'h400);
    check("miss_pc0", at_q(cons_pc, cb), 32'h400);
    check("miss_no200", 32'(count_of(cons_pc, cb, 32'h200)), 32'h0);

    // Redirect coinciding with the response for 0x10C.
    miss_addr = 32'h1;
    miss_lat  = 2;
    do_reset(1'b1);
    do_redirect(1, 32'h10C, 32'h800, "same_redir");
    tick(8);
    check("same_a3", at_q(issued, ib + 3), 32'h10C);
    check("same_a4", at_q(issued, ib + 4), 32'h800);
    check("same_pc3", at_q(cons_pc, cb + 3), 32'h800);
    check("same_no10c", 32'(count_of(cons_pc, cb, 32'h10C)), 32'h0);

    // Two redirects while the killed access is still outstanding.
    miss_addr = 32'h100;
    miss_lat  = 12;
    do_reset(1'b1);
    wait_issued(ib + 1, "kill_issue");
    tick(1);
    do_redirect(0, 32'h0, 32'h500, "kill_r1");
    do_redirect(0, 32'h0, 32'h600, "kill_r2");
    tick(20);
    check("kill_a1", at_q(issued, ib + 1), 32'h600);
    check("kill_a2", at_q(issued, ib + 2), 32'h604);
    check("kill_no500", 32'(count_of(issued, ib, 32'h500)), 32'h0);
    check("kill_pc0", at_q(cons_pc, cb), 32'h600);

    // PC wraps from the top of the address space.
    miss_addr = 32'h1;
    miss_lat  = 2;
    do_reset(1'b0);
    tick(10);
    ib = issued.size();
    cb = cons_pc.size();
    do_redirect(0, 32'h0, 32'hFFFF_FFFC, "wrap_redir");
    id_ready = 1'b1;
    tick(12);
    check("wrap_a0", at_q(issued, ib), 32'hFFFF_FFFC);
    check("wrap_a1", at_q(issued, ib + 1), 32'h0);
    check("wrap_a2", at_q(issued, ib + 2), 32'h4);
    check("wrap_pc0", at_q(cons_pc, cb), 32'hFFFF_FFFC);
    check("wrap_pc1", at_q(cons_pc, cb + 1), 32'h0);

    // Asynchronous reset with an outstanding miss and a buffered instruction.
    miss_addr = 32'h104;
    miss_lat  = 12;
    do_reset(1'b0);
    wait_issued(ib + 2, "arst_issue");
    tick(3);
    check("arst_pre_req", 32'(cache_req), 32'h1);
    check("arst_pre_valid", 32'(if_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(cache_req), 32'h0);
    check("arst_valid", 32'(if_valid), 32'h0);
    check("arst_addr", cache_addr, 32'h100);
    tick(2);
    rst_n    = 1'b1;
    id_ready = 1'b1;
    ib       = issued.size();
    cb       = cons_pc.size();
    tick(10);
    check("arst_a0", at_q(issued, ib), 32'h100);
    check("arst_pc0", at_q(cons_pc, cb), 32'h100);

    check("addr_stable", 32'(stab_err), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the instruction cache.
- Generates sequential PCs, drives the cache request/address handshake, and absorbs branch/jump redirects from execute.
- Buffers returned instructions in a small FIFO toward decode, which applies backpressure via id_ready.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
ADDR_WIDTH, 32, PC/address width
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cache_req  output  1  fetch request to icache
cache_addr  output  ADDR_WIDTH  fetch address, word aligned
cache_ready  input  1  one-cycle pulse: cache_rdata valid for cache_addr
cache_rdata  input  32  instruction word
redirect_valid  input  1  one-cycle pulse: change fetch PC
redirect_pc  input  ADDR_WIDTH  new PC; bits [1:0] ignored and forced to 0
if_valid  output  1  instruction available to decode
if_pc  output  ADDR_WIDTH  PC of head instruction
if_instr  output  32  head instruction
id_ready  input  1  decode consumes head when if_valid && id_ready

Behaviour:
- Clocking: one clock; reset is asynchronous, active-low (rst_n), ports clk/rst_n.
- Reset values: cache_req=0, cache_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, FIFO empty, state IDLE, fetch_pc=RESET_PC. Reset asserted mid-access drops the request immediately. The cache is reset by the same rst_n.
- Cache contract: cache_req and cache_addr are registered. Once cache_req=1, cache_addr is held stable until the edge on which cache_ready=1 is sampled. The cache uses the address combinationally through the refill, so the address must never change mid-access. Only one access is outstanding. cache_req may stay high back-to-back; a new address is presented on the edge after cache_ready. A hit costs at least 2 cycles.
- Credit rule: issue only if fifo_count + outstanding < FIFO_DEPTH. A pop in the same cycle counts as freeing a slot.
- FSM:
  - IDLE: cache_req=0. Go to WAIT and assert req with addr=fetch_pc when credit is available and there is no redirect this cycle. A redirect in IDLE loads fetch_pc; the request issues on the next edge.
  - WAIT: on cache_ready without redirect: push {cache_addr, cache_rdata}, fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH). Then stay in WAIT with a new addr if credit remains, else go to IDLE.
  - WAIT with redirect and no cache_ready: flush the FIFO, latch redirect_pc into fetch_pc, go to KILL. cache_req/addr stay unchanged.
  - WAIT with redirect and cache_ready in the same cycle: drop the response, flush, fetch_pc=redirect_pc, then reissue at redirect_pc (WAIT) on the next edge.
  - KILL: hold req/addr. A further redirect overwrites fetch_pc. On cache_ready: discard rdata (no push), then go to WAIT with addr=fetch_pc. If a redirect coincides with that ready, use the new redirect_pc.
- FIFO: if_valid = !empty; if_pc/if_instr are the head entry (registered storage, combinational read).
  - A push and a pop in the same cycle are both legal.
  - Flush on redirect overrides any same-cycle push or pop; if_valid=0 on the following cycle.
  - No push when full; the credit rule guarantees this, and an assertion must flag any violation.
- Stale-fetch guarantee: after a redirect, no instruction with a pre-redirect PC ever reaches decode.
- Reads only; unaligned or unmapped PCs are not checked.

Test Plan:
- Reset with RESET_PC=0x100, cache model 2-cycle hit, id_ready=1 -> cache_addr sequence 0x100,0x104,0x108; if_pc matches with if_instr=model data; cache_addr never changes while req=1 before ready.
- id_ready=0 for 10 cycles -> exactly 2 entries buffered (0x100, 0x104), cache_req drops, no third access; on id_ready=1, fetch resumes at 0x108 and ordering is preserved.
- Miss of 12 cycles at 0x200 with redirect to 0x403 on cycle 5 -> addr held 0x200 until ready, response discarded, next request 0x400, first if_pc=0x400.
- Redirect to 0x800 in the same cycle as cache_ready for 0x10C -> 0x10C never appears on if_pc; next cache_addr=0x800; FIFO flushed even with id_ready=1 that cycle.
- Two redirects during KILL (0x500 then 0x600) -> single reissue at 0x600.
- fetch_pc=0xFFFF_FFFC -> next address 0x0000_0000; rst_n low during an outstanding miss -> cache_req=0 and if_valid=0 asynchronously, restart at RESET_PC.
